// File: rtl/hd_program_loader_pkg.sv
// Shared constants and types for the HD-to-instruction-memory program loader.
// BLOCK_SIZE is also used by instruction memory, so slot stride and its cursor advance stay in step.
package hd_program_loader_pkg;

    localparam int unsigned BLOCK_SIZE  = 200;
    localparam int unsigned HD_TRACK    = 256;
    localparam int unsigned NUM_SLOTS   = 10;
    localparam int unsigned HD_LEN_WORD = 0;

    localparam logic [1:0] CTRL_ON  = 2'b01;
    localparam logic [1:0] CTRL_OFF = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_REQ,
        S_LEN_WAIT,
        S_STREAM,
        S_FIM,
        S_ERR
    } state_t;

    function automatic logic load_ok(input logic [31:0] n, input logic [3:0] slot);
        return (n >= 32'd1) && (n <= BLOCK_SIZE) && (32'(slot) < NUM_SLOTS);
    endfunction

endpackage

// File: rtl/hd_program_loader_if.sv
// Load-request, HD read and instruction-memory load-port signals of the program loader.
// master = loader side, slave = the HD model / instruction memory / control path side.
interface hd_program_loader_if;

    logic        start;
    logic [3:0]  program_id;
    logic [3:0]  slot;
    logic [31:0] hd_data;
    logic        hd_rd_en;
    logic [31:0] hd_addr;
    logic [31:0] entradaDeInstrucao;
    logic [1:0]  controleSalvaInstrucao;
    logic [1:0]  ControleFimDeLeitura;
    logic [31:0] inst_addr;
    logic        busy;
    logic        done;
    logic        load_error;

    modport master (
        input  start, program_id, slot, hd_data,
        output hd_rd_en, hd_addr, entradaDeInstrucao, controleSalvaInstrucao,
        output ControleFimDeLeitura, inst_addr, busy, done, load_error
    );

    modport slave (
        output start, program_id, slot, hd_data,
        input  hd_rd_en, hd_addr, entradaDeInstrucao, controleSalvaInstrucao,
        input  ControleFimDeLeitura, inst_addr, busy, done, load_error
    );

endinterface

// File: rtl/hd_program_loader.sv
// Copies one length-prefixed program from its HD track into a BLOCK_SIZE instruction-memory slot.
// Latency start->end-of-read is N+4 cycles; starts while busy are dropped, there is no input backpressure.
module hd_program_loader
    import hd_program_loader_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    hd_program_loader_if.master ldr
);

    state_t      state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [7:0]  rd_left_q, rd_left_d;
    logic        data_vld_q, data_vld_d;
    logic [31:0] wr_addr_q, wr_addr_d;

    logic        hd_rd_en_q, hd_rd_en_d;
    logic [31:0] hd_addr_q, hd_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  save_q, save_d;
    logic [1:0]  fim_q, fim_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        rd_left_d   = rd_left_q;
        wr_addr_d   = wr_addr_q;
        hd_addr_d   = hd_addr_q;
        instr_d     = instr_q;
        inst_addr_d = inst_addr_q;
        busy_d      = busy_q;
        hd_rd_en_d  = 1'b0;
        save_d      = CTRL_OFF;
        fim_d       = CTRL_OFF;
        done_d      = 1'b0;
        err_d       = 1'b0;
        // A read issued this cycle returns data that is valid for the whole next cycle.
        data_vld_d  = hd_rd_en_q;

        case (state_q)
            S_IDLE: begin
                if (ldr.start) begin
                    state_d    = S_LEN_REQ;
                    slot_d     = ldr.slot;
                    busy_d     = 1'b1;
                    hd_rd_en_d = 1'b1;
                    hd_addr_d  = 32'(ldr.program_id) * HD_TRACK + HD_LEN_WORD;
                end
            end
            S_LEN_REQ: begin
                state_d    = S_LEN_WAIT;
                hd_rd_en_d = 1'b1;
                hd_addr_d  = hd_addr_q + 32'd1;
            end
            S_LEN_WAIT: begin
                if (load_ok(ldr.hd_data, slot_q)) begin
                    state_d   = S_STREAM;
                    wr_addr_d = 32'(slot_q) * BLOCK_SIZE;
                    rd_left_d = 8'd0;
                    // Word 1 is already in flight; word 2 goes out now when it exists.
                    if (ldr.hd_data >= 32'd2) begin
                        hd_rd_en_d = 1'b1;
                        hd_addr_d  = hd_addr_q + 32'd1;
                        rd_left_d  = 8'(ldr.hd_data - 32'd2);
                    end
                end else begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_STREAM: begin
                if (rd_left_q != 8'd0) begin
                    hd_rd_en_d = 1'b1;
                    hd_addr_d  = hd_addr_q + 32'd1;
                    rd_left_d  = rd_left_q - 8'd1;
                end
                if (data_vld_q) begin
                    save_d      = CTRL_ON;
                    instr_d     = ldr.hd_data;
                    inst_addr_d = wr_addr_q;
                    wr_addr_d   = wr_addr_q + 32'd1;
                end
                // Pipeline drained: no read outstanding and no word waiting.
                if (!hd_rd_en_q && !data_vld_q) begin
                    state_d = S_FIM;
                    fim_d   = CTRL_ON;
                    done_d  = 1'b1;
                end
            end
            S_FIM, S_ERR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            slot_q      <= 4'd0;
            rd_left_q   <= 8'd0;
            data_vld_q  <= 1'b0;
            wr_addr_q   <= 32'd0;
            hd_rd_en_q  <= 1'b0;
            hd_addr_q   <= 32'd0;
            instr_q     <= 32'd0;
            save_q      <= CTRL_OFF;
            fim_q       <= CTRL_OFF;
            inst_addr_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            rd_left_q   <= rd_left_d;
            data_vld_q  <= data_vld_d;
            wr_addr_q   <= wr_addr_d;
            hd_rd_en_q  <= hd_rd_en_d;
            hd_addr_q   <= hd_addr_d;
            instr_q     <= instr_d;
            save_q      <= save_d;
            fim_q       <= fim_d;
            inst_addr_q <= inst_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ldr.hd_rd_en               = hd_rd_en_q;
    assign ldr.hd_addr                = hd_addr_q;
    assign ldr.entradaDeInstrucao     = instr_q;
    assign ldr.controleSalvaInstrucao = save_q;
    assign ldr.ControleFimDeLeitura   = fim_q;
    assign ldr.inst_addr              = inst_addr_q;
    assign ldr.busy                   = busy_q;
    assign ldr.done                   = done_q;
    assign ldr.load_error             = err_q;

endmodule

// File: tb/tb_hd_program_loader.sv
// Directed bench for hd_program_loader: an HD word-store model plus per-scenario checks
// of read addresses, write strobes, end-of-read timing and the error path.
module tb_hd_program_loader;

    logic clock = 1'b0;
    logic reset = 1'b1;

    hd_program_loader_if ifc();

    hd_program_loader dut (
        .clock (clock),
        .reset (reset),
        .ldr   (ifc)
    );

    always #5 clock = ~clock;

    logic [31:0] hd_mem [0:4095];

    // HD: address sampled on the edge with hd_rd_en, data held for the following cycle.
    always @(posedge clock) begin
        if (reset) ifc.hd_data <= 32'd0;
        else if (ifc.hd_rd_en === 1'b1) ifc.hd_data <= hd_mem[ifc.hd_addr[11:0]];
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_lo = -1;
    int          wr_cyc[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [1:0]  wr_v[$];
    int          rd_cyc[$];
    logic [31:0] rd_a[$];
    int          fim_cyc[$];
    int          done_cyc[$];
    int          err_cyc[$];

    function automatic logic [31:0] word_val(input int pid, input int k);
        return {4'hA, 4'(pid), 8'h5C, 16'(k)};
    endfunction

    function automatic int first_of(input int q[$]);
        if (q.size() == 0) return -1;
        return q[0];
    endfunction

    task automatic fill_track(input int pid, input int n);
        hd_mem[pid*256] = 32'(n);
        for (int k = 1; k < 256; k++) hd_mem[pid*256 + k] = word_val(pid, k);
    endtask

    task automatic clear_log();
        wr_cyc.delete(); wr_a.delete(); wr_d.delete(); wr_v.delete();
        rd_cyc.delete(); rd_a.delete();
        fim_cyc.delete(); done_cyc.delete(); err_cyc.delete();
        busy_lo = -1;
        cyc = 0;
    endtask

    // Advance one cycle and record every visible event of the new cycle.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (ifc.controleSalvaInstrucao !== 2'b00) begin
            wr_cyc.push_back(cyc);
            wr_a.push_back(ifc.inst_addr);
            wr_d.push_back(ifc.entradaDeInstrucao);
            wr_v.push_back(ifc.controleSalvaInstrucao);
        end
        if (ifc.hd_rd_en !== 1'b0) begin
            rd_cyc.push_back(cyc);
            rd_a.push_back(ifc.hd_addr);
        end
        if (ifc.ControleFimDeLeitura !== 2'b00) fim_cyc.push_back(cyc);
        if (ifc.done !== 1'b0) done_cyc.push_back(cyc);
        if (ifc.load_error !== 1'b0) err_cyc.push_back(cyc);
        if (ifc.busy === 1'b0 && busy_lo < 0) busy_lo = cyc;
    endtask

    // Called one #1 after an edge: start is high for this cycle (cycle 0).
    task automatic launch(input int pid, input int sl);
        clear_log();
        ifc.start      = 1'b1;
        ifc.program_id = 4'(pid);
        ifc.slot       = 4'(sl);
        step();
        ifc.start      = 1'b0;
        ifc.program_id = 4'hF;
        ifc.slot       = 4'hF;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy_lo < 0 && n < limit) begin
            step();
            n++;
        end
        repeat (4) step();
        tests++;
        if (busy_lo < 0) begin
            fails++;
            $display("FAIL %s_timeout: busy still high after %0d cycles, required low", name, limit);
        end
    endtask

    task automatic test_reset();
        ifc.start = 1'b0; ifc.program_id = 4'd0; ifc.slot = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", ifc.busy); end
        tests++; if (ifc.hd_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %b want 0", ifc.hd_rd_en); end
        tests++; if (ifc.hd_addr !== 32'd0) begin fails++; $display("FAIL rst_hd_addr: got %0h want 0", ifc.hd_addr); end
        tests++; if (ifc.entradaDeInstrucao !== 32'd0) begin fails++; $display("FAIL rst_data: got %0h want 0", ifc.entradaDeInstrucao); end
        tests++; if (ifc.controleSalvaInstrucao !== 2'b00) begin fails++; $display("FAIL rst_save: got %b want 00", ifc.controleSalvaInstrucao); end
        tests++; if (ifc.ControleFimDeLeitura !== 2'b00) begin fails++; $display("FAIL rst_fim: got %b want 00", ifc.ControleFimDeLeitura); end
        tests++; if (ifc.inst_addr !== 32'd0) begin fails++; $display("FAIL rst_inst_addr: got %0h want 0", ifc.inst_addr); end
        tests++; if (ifc.done !== 1'b0 || ifc.load_error !== 1'b0) begin fails++; $display("FAIL rst_pulses: got done=%b err=%b want 0 0", ifc.done, ifc.load_error); end
        reset = 1'b0;
        clear_log();
        repeat (4) step();
        tests++; if (rd_a.size() != 0 || ifc.busy !== 1'b0) begin fails++; $display("FAIL idle_quiet: got %0d reads busy=%b want 0 reads busy=0", rd_a.size(), ifc.busy); end
    endtask

    task automatic test_basic();
        launch(2, 1);
        wait_idle("basic", 40);
        tests++; if (rd_a.size() != 4) begin fails++; $display("FAIL basic_rd_count: got %0d want 4", rd_a.size()); end
        for (int i = 0; i < rd_a.size() && i < 4; i++) begin
            tests++;
            if (rd_a[i] !== 32'(512 + i) || rd_cyc[i] != 1 + i) begin
                fails++; $display("FAIL basic_rd%0d: got addr %0d cyc %0d want %0d cyc %0d", i, rd_a[i], rd_cyc[i], 512 + i, 1 + i);
            end
        end
        tests++; if (wr_cyc.size() != 3) begin fails++; $display("FAIL basic_wr_count: got %0d want 3", wr_cyc.size()); end
        for (int i = 0; i < wr_cyc.size() && i < 3; i++) begin
            tests++;
            if (wr_cyc[i] != 4 + i || wr_a[i] !== 32'(200 + i) || wr_d[i] !== word_val(2, i + 1) || wr_v[i] !== 2'b01) begin
                fails++; $display("FAIL basic_wr%0d: got cyc %0d addr %0d data %h ctl %b want cyc %0d addr %0d data %h ctl 01",
                                  i, wr_cyc[i], wr_a[i], wr_d[i], wr_v[i], 4 + i, 200 + i, word_val(2, i + 1));
            end
        end
        tests++; if (fim_cyc.size() != 1 || first_of(fim_cyc) != 7) begin fails++; $display("FAIL basic_fim: got %0d pulses first %0d want 1 at 7", fim_cyc.size(), first_of(fim_cyc)); end
        tests++; if (done_cyc.size() != 1 || first_of(done_cyc) != 7) begin fails++; $display("FAIL basic_done: got %0d pulses first %0d want 1 at 7", done_cyc.size(), first_of(done_cyc)); end
        tests++; if (busy_lo != 8) begin fails++; $display("FAIL basic_busy_low: got cycle %0d want 8", busy_lo); end
        tests++; if (err_cyc.size() != 0) begin fails++; $display("FAIL basic_err: got %0d pulses want 0", err_cyc.size()); end
    endtask

    task automatic test_bad_load(input string name, input int pid, input int sl);
        launch(pid, sl);
        wait_idle(name, 20);
        tests++; if (err_cyc.size() != 1 || first_of(err_cyc) != 3) begin fails++; $display("FAIL %s_err: got %0d pulses first %0d want 1 at 3", name, err_cyc.size(), first_of(err_cyc)); end
        tests++; if (wr_cyc.size() != 0) begin fails++; $display("FAIL %s_writes: got %0d want 0", name, wr_cyc.size()); end
        tests++; if (fim_cyc.size() != 0 || done_cyc.size() != 0) begin fails++; $display("FAIL %s_fim: got fim %0d done %0d want 0 0", name, fim_cyc.size(), done_cyc.size()); end
        tests++; if (busy_lo != 4) begin fails++; $display("FAIL %s_busy_low: got cycle %0d want 4", name, busy_lo); end
        tests++; if (rd_a.size() != 2) begin fails++; $display("FAIL %s_reads: got %0d want 2", name, rd_a.size()); end
    endtask

    task automatic test_full_block();
        int bad = 0;
        launch(6, 9);
        wait_idle("full", 260);
        tests++; if (wr_cyc.size() != 200) begin fails++; $display("FAIL full_wr_count: got %0d want 200", wr_cyc.size()); end
        for (int i = 0; i < wr_cyc.size(); i++)
            if (wr_cyc[i] != 4 + i || wr_a[i] !== 32'(1800 + i) || wr_d[i] !== word_val(6, i + 1)) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL full_wr_seq: got %0d bad strobes want 0", bad); end
        tests++; if (rd_a.size() != 201 || rd_a[rd_a.size()-1] !== 32'd1736) begin fails++; $display("FAIL full_last_rd: got %0d reads last %0d want 201 last 1736", rd_a.size(), rd_a[rd_a.size()-1]); end
        tests++; if (fim_cyc.size() != 1 || first_of(fim_cyc) != 204) begin fails++; $display("FAIL full_fim: got %0d pulses first %0d want 1 at 204", fim_cyc.size(), first_of(fim_cyc)); end
    endtask

    task automatic test_start_ignored();
        launch(7, 3);
        while (cyc < 5) step();
        ifc.start = 1'b1; ifc.program_id = 4'd2; ifc.slot = 4'd0;
        step();
        ifc.start = 1'b0;
        wait_idle("busy_start", 40);
        repeat (10) step();
        tests++; if (wr_cyc.size() != 4) begin fails++; $display("FAIL busy_start_writes: got %0d want 4", wr_cyc.size()); end
        for (int i = 0; i < wr_cyc.size() && i < 4; i++) begin
            tests++;
            if (wr_a[i] !== 32'(600 + i) || wr_d[i] !== word_val(7, i + 1)) begin
                fails++; $display("FAIL busy_start_wr%0d: got addr %0d data %h want %0d %h", i, wr_a[i], wr_d[i], 600 + i, word_val(7, i + 1));
            end
        end
        tests++; if (done_cyc.size() != 1 || first_of(done_cyc) != 8) begin fails++; $display("FAIL busy_start_done: got %0d pulses first %0d want 1 at 8", done_cyc.size(), first_of(done_cyc)); end
    endtask

    task automatic test_reset_mid_load();
        launch(8, 4);
        while (cyc < 5) step();
        reset = 1'b1;
        #1;
        tests++;
        if ({ifc.busy, ifc.hd_rd_en, ifc.done, ifc.load_error, ifc.controleSalvaInstrucao, ifc.ControleFimDeLeitura} !== 8'd0 ||
            ifc.hd_addr !== 32'd0 || ifc.inst_addr !== 32'd0 || ifc.entradaDeInstrucao !== 32'd0) begin
            fails++; $display("FAIL midrst_outputs: got busy=%b rd=%b save=%b addr=%0h inst=%0h want all 0",
                              ifc.busy, ifc.hd_rd_en, ifc.controleSalvaInstrucao, ifc.hd_addr, ifc.inst_addr);
        end
        tests++; if (wr_cyc.size() != 2 || fim_cyc.size() != 0) begin fails++; $display("FAIL midrst_before: got %0d writes %0d fim want 2 0", wr_cyc.size(), fim_cyc.size()); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_log();
        repeat (6) step();
        tests++; if (fim_cyc.size() != 0 || wr_cyc.size() != 0 || rd_a.size() != 0) begin fails++; $display("FAIL midrst_after: got fim %0d wr %0d rd %0d want 0 0 0", fim_cyc.size(), wr_cyc.size(), rd_a.size()); end
        launch(9, 5);
        wait_idle("postrst", 30);
        tests++; if (done_cyc.size() != 1 || first_of(done_cyc) != 6 || first_of(fim_cyc) != 6) begin fails++; $display("FAIL postrst_done: got %0d pulses done %0d fim %0d want 1 at 6", done_cyc.size(), first_of(done_cyc), first_of(fim_cyc)); end
        tests++;
        if (wr_cyc.size() != 2 || wr_a[0] !== 32'd1000 || wr_a[1] !== 32'd1001 || wr_d[0] !== word_val(9, 1) || wr_d[1] !== word_val(9, 2)) begin
            fails++; $display("FAIL postrst_writes: got %0d writes first addr %0d want 2 at 1000,1001", wr_cyc.size(), wr_a[0]);
        end
        tests++; if (busy_lo != 7) begin fails++; $display("FAIL postrst_busy_low: got cycle %0d want 7", busy_lo); end
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.program_id = 4'd0;
        ifc.slot = 4'd0;
        for (int p = 0; p < 16; p++) fill_track(p, 1);
        fill_track(2, 3);
        fill_track(3, 0);
        fill_track(4, 201);
        fill_track(5, 5);
        fill_track(6, 200);
        fill_track(7, 4);
        fill_track(8, 10);
        fill_track(9, 2);

        test_reset();
        test_basic();
        test_bad_load("len0", 3, 0);
        test_bad_load("len201", 4, 2);
        test_bad_load("slot10", 5, 10);
        test_full_block();
        test_start_ignored();
        test_reset_mid_load();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

endmodule
